out_of_order_buffer_multiport: RTL

OUT_OF_ORDER_BUFFER_MULTIPORT -- requirements
Module: out_of_order_buffer_multiport

---
 rtl/out_of_order_buffer_multiport.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/out_of_order_buffer_multiport.sv
// Out-of-order slot buffer: writes take the lowest free slot, any number of read
// channels read/free arbitrary slots by index, optionally with registered outputs.

module ooo_read_chan #(
    parameter int WIDTH           = 8,
    parameter int DEPTH           = 8,
    parameter int INDEX_WIDTH     = 3,
    parameter bit REGISTERED_READ = 1'b0
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic                        read_enable_i,
    input  logic                        read_clear_i,
    input  logic [INDEX_WIDTH-1:0]      read_index_i,
    input  logic [DEPTH-1:0]            valid_i,
    input  logic [DEPTH-1:0][WIDTH-1:0] mem_i,
    output logic [WIDTH-1:0]            read_data_o,
    output logic                        read_error_o,
    output logic [DEPTH-1:0]            clear_o
);

    logic             hit;
    logic [WIDTH-1:0] rd_data;
    logic             rd_err;
    logic [WIDTH-1:0] rdata_q;
    logic             rerr_q;

    // Index compare loop also treats out-of-range indexes (non power-of-two DEPTH) as invalid.
    always_comb begin
        hit     = 1'b0;
        rd_data = '0;
        clear_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (read_index_i == INDEX_WIDTH'(i)) begin
                hit     = valid_i[i];
                rd_data = mem_i[i];
            end
        end
        rd_err = read_enable_i && !hit;
        for (int i = 0; i < DEPTH; i++) begin
            clear_o[i] = read_enable_i && read_clear_i && hit && (read_index_i == INDEX_WIDTH'(i));
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rdata_q <= '0;
            rerr_q  <= 1'b0;
        end else begin
            rerr_q <= rd_err;
            if (read_enable_i) begin
                rdata_q <= rd_data;
            end
        end
    end

    assign read_data_o  = REGISTERED_READ ? rdata_q : rd_data;
    assign read_error_o = REGISTERED_READ ? rerr_q  : rd_err;

endmodule

module out_of_order_buffer_multiport #(
    parameter int WIDTH           = 8,
    parameter int DEPTH           = 8,
    parameter int INDEX_WIDTH     = $clog2(DEPTH),
    parameter int READ_PORTS      = 2,
    parameter bit REGISTERED_READ = 1'b0
) (
    input  logic                              clock,
    input  logic                              resetn,
    output logic                              full,
    output logic                              empty,
    output logic [$clog2(DEPTH+1)-1:0]        count,
    input  logic                              write_enable,
    input  logic [WIDTH-1:0]                  write_data,
    output logic [INDEX_WIDTH-1:0]            write_index,
    output logic                              write_error,
    input  logic [READ_PORTS-1:0]             read_enable,
    input  logic [READ_PORTS-1:0]             read_clear,
    input  logic [READ_PORTS*INDEX_WIDTH-1:0] read_index,
    output logic [READ_PORTS*WIDTH-1:0]       read_data,
    output logic [READ_PORTS-1:0]             read_error
);

    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0][WIDTH-1:0]      mem_q;
    logic [DEPTH-1:0]                 valid_q, valid_d;
    logic [CW-1:0]                    count_q, count_d;
    logic [INDEX_WIDTH-1:0]           widx;
    logic                             write_ok;
    logic [DEPTH-1:0]                 wr_set;
    logic [READ_PORTS-1:0][DEPTH-1:0] clear_chan;
    logic [DEPTH-1:0]                 clear_all;
    logic [CW-1:0]                    clr_cnt;

    assign full        = (count_q == CW'(DEPTH));
    assign empty       = (count_q == '0);
    assign count       = count_q;
    assign write_index = widx;
    assign write_ok    = write_enable && !full;
    assign write_error = write_enable && full;

    // Lowest invalid slot wins; stays 0 when every slot is valid.
    always_comb begin
        widx = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                widx = INDEX_WIDTH'(i);
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < READ_PORTS; g++) begin : g_chan
            ooo_read_chan #(
                .WIDTH          (WIDTH),
                .DEPTH          (DEPTH),
                .INDEX_WIDTH    (INDEX_WIDTH),
                .REGISTERED_READ(REGISTERED_READ)
            ) u_chan (
                .clock        (clock),
                .resetn       (resetn),
                .read_enable_i(read_enable[g]),
                .read_clear_i (read_clear[g]),
                .read_index_i (read_index[g*INDEX_WIDTH +: INDEX_WIDTH]),
                .valid_i      (valid_q),
                .mem_i        (mem_q),
                .read_data_o  (read_data[g*WIDTH +: WIDTH]),
                .read_error_o (read_error[g]),
                .clear_o      (clear_chan[g])
            );
        end
    endgenerate

    // OR-merging the per-channel clears makes duplicate frees of one slot count once.
    always_comb begin
        clear_all = '0;
        for (int n = 0; n < READ_PORTS; n++) begin
            clear_all = clear_all | clear_chan[n];
        end
        clr_cnt = '0;
        wr_set  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            clr_cnt   = clr_cnt + CW'(clear_all[i]);
            wr_set[i] = write_ok && (widx == INDEX_WIDTH'(i));
        end
        valid_d = (valid_q & ~clear_all) | wr_set;
        count_d = count_q + CW'(write_ok) - clr_cnt;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_set[i]) begin
                mem_q[i] <= write_data;
            end
        end
    end

endmodule
